mat_mult_gen: RTL and testbench

MAT_MULT_GEN -- requirements
Module: mat_mult_gen

---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_mac.sv | 38 +++
 rtl/mat_mult_gen.sv | 157 +++++++++++++++
 tb/tb_mat_mult_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types, default sizes and a constant clog2 for the matrix multiplier.
package mm_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefMaxDim = 4;
  localparam int unsigned DefAccW = 20;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StCheck,
    StCalc,
    StIllegal,
    StOut
  } mm_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate with synchronous clear; operands sign- or zero-extended.
module mm_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  localparam int unsigned ProdW = 2 * DATA_W + 2;

  logic signed [DATA_W:0]  a_ext, b_ext;
  logic signed [ProdW-1:0] prod;
  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W-1:0]        acc_q;

  assign a_ext = signed'({is_signed & a[DATA_W-1], a});
  assign b_ext = signed'({is_signed & b[DATA_W-1], b});
  assign prod  = ProdW'(a_ext) * ProdW'(b_ext);
  // Casting a signed value widens by sign extension.
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mat_mult_gen.sv
// Streaming matrix multiplier: loads A then B row-major, checks shapes, then
// emits C = A*B one element per handshake, computed with a single MAC.
module mat_mult_gen
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MAX_DIM = DefMaxDim,
  parameter int unsigned ACC_W   = DefAccW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              col_end,
  input  logic              row_end,
  input  logic              is_signed,
  output logic              busy,
  input  logic              out_ready,
  output logic              valid,
  output logic              is_legal,
  output logic [ACC_W-1:0]  out_data,
  output logic              change_row
);
  localparam int unsigned IdxW = (clog2(MAX_DIM) > 0) ? clog2(MAX_DIM) : 1;
  localparam int unsigned CW = clog2(MAX_DIM + 1) + 1;
  localparam logic [CW-1:0] DimMax = CW'(MAX_DIM);
  localparam logic [CW-1:0] DimSat = CW'(MAX_DIM + 1);

  if (ACC_W < 2 * DATA_W + clog2(MAX_DIM)) begin : g_acc_w_check
    $error("ACC_W too narrow for exact dot products");
  end

  mm_state_e state_q, state_d;

  // Load counters saturate one past MAX_DIM so oversize shapes still fail the check.
  logic [CW-1:0]     col_cnt, row_cnt, first_cols, elem_cols, rows_next;
  logic [CW-1:0]     a_rows, a_cols, b_rows, b_cols;
  logic              shape_bad, signed_mode, legal_q;
  logic [IdxW-1:0]   ci, cj, ck;
  logic [DATA_W-1:0] a_mat [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] b_mat [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] a_op, b_op;
  logic [ACC_W-1:0]  acc;
  logic              accept, legal_chk, k_last, j_last, i_last, last_beat, beat_take;

  assign busy      = !(state_q == StLoadA || state_q == StLoadB);
  assign accept    = in_valid && !busy;
  assign elem_cols = (col_cnt >= DimSat) ? DimSat : col_cnt + CW'(1);
  assign rows_next = (row_cnt >= DimSat) ? DimSat : row_cnt + CW'(1);
  assign legal_chk = !shape_bad && (a_cols == b_rows) && (a_rows <= DimMax) &&
                     (a_cols <= DimMax) && (b_cols <= DimMax);
  assign k_last    = (CW'(ck) == a_cols - CW'(1));
  assign j_last    = (CW'(cj) == b_cols - CW'(1));
  assign i_last    = (CW'(ci) == a_rows - CW'(1));
  assign beat_take = (state_q == StOut) && out_ready;
  assign last_beat = !legal_q || (i_last && j_last);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StLoadA;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoadA:   if (accept && row_end) state_d = StLoadB;
      StLoadB:   if (accept && row_end) state_d = StCheck;
      StCheck:   state_d = legal_chk ? StCalc : StIllegal;
      StCalc:    if (k_last) state_d = StOut;
      StIllegal: state_d = StOut;
      StOut:     if (out_ready) state_d = last_beat ? StLoadA : StCalc;
      default:   state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0; row_cnt <= '0; first_cols <= '0;
      a_rows <= '0; a_cols <= '0; b_rows <= '0; b_cols <= '0;
      shape_bad <= 1'b0; signed_mode <= 1'b0; legal_q <= 1'b0;
      ci <= '0; cj <= '0; ck <= '0;
      for (int r = 0; r < int'(MAX_DIM); r++) begin
        for (int c = 0; c < int'(MAX_DIM); c++) begin
          a_mat[r][c] <= '0;
          b_mat[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        if (col_cnt < DimMax && row_cnt < DimMax) begin
          if (state_q == StLoadA) a_mat[row_cnt[IdxW-1:0]][col_cnt[IdxW-1:0]] <= in_data;
          else                    b_mat[row_cnt[IdxW-1:0]][col_cnt[IdxW-1:0]] <= in_data;
        end
        if (state_q == StLoadA && row_cnt == '0 && col_cnt == '0) signed_mode <= is_signed;
        // row_end also closes the current row.
        if (col_end || row_end) begin
          col_cnt <= '0;
          row_cnt <= rows_next;
          if (row_cnt == '0)               first_cols <= elem_cols;
          else if (elem_cols != first_cols) shape_bad <= 1'b1;
        end else begin
          col_cnt <= elem_cols;
        end
        if (row_end) begin
          row_cnt    <= '0;
          first_cols <= '0;
          if (state_q == StLoadA) begin
            a_rows <= rows_next;
            a_cols <= (row_cnt == '0) ? elem_cols : first_cols;
          end else begin
            b_rows <= rows_next;
            b_cols <= (row_cnt == '0) ? elem_cols : first_cols;
          end
        end
      end
      if (state_q == StCheck) begin
        legal_q <= legal_chk;
        ci <= '0; cj <= '0; ck <= '0;
      end
      if (state_q == StCalc) ck <= k_last ? '0 : ck + IdxW'(1);
      if (beat_take) begin
        if (last_beat) begin
          shape_bad <= 1'b0; legal_q <= 1'b0;
          ci <= '0; cj <= '0;
        end else if (j_last) begin
          cj <= '0;
          ci <= ci + IdxW'(1);
        end else begin
          cj <= cj + IdxW'(1);
        end
      end
    end
  end

  assign a_op = a_mat[ci][ck];
  assign b_op = b_mat[ck][cj];

  mm_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      ((state_q == StCheck) || beat_take),
    .en       (state_q == StCalc),
    .is_signed(signed_mode),
    .a        (a_op),
    .b        (b_op),
    .acc      (acc)
  );

  assign valid      = (state_q == StOut);
  assign is_legal   = valid && legal_q;
  assign out_data   = is_legal ? acc : '0;
  assign change_row = is_legal && j_last;

endmodule

// File: tb/tb_mat_mult_gen.sv
// Directed self-checking bench for mat_mult_gen with default parameters.
module tb_mat_mult_gen;
  logic        clk = 1'b0;
  logic        rst, in_valid, col_end, row_end, is_signed, out_ready;
  logic [7:0]  in_data;
  logic        busy, valid, is_legal, change_row;
  logic [19:0] out_data;
  int          total = 0;
  int          bad = 0;
  int          mv [16];

  mat_mult_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .col_end   (col_end),
    .row_end   (row_end),
    .is_signed (is_signed),
    .busy      (busy),
    .out_ready (out_ready),
    .valid     (valid),
    .is_legal  (is_legal),
    .out_data  (out_data),
    .change_row(change_row)
  );

  always #5 clk = ~clk;

  task automatic send_elem(input logic [7:0] d, input logic ce, input logic re, input logic sg);
    in_valid = 1'b1; in_data = d; col_end = ce; row_end = re; is_signed = sg;
    @(posedge clk); #1;
    in_valid = 1'b0; col_end = 1'b0; row_end = 1'b0;
  endtask

  task automatic send_mat(input int rows, input int cols, input logic sg);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        send_elem(8'(mv[r * cols + c]), c == cols - 1, (r == rows - 1) && (c == cols - 1), sg);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (is_legal !== 1'b0) begin bad++; $display("FAIL reset_legal: got %b want 0", is_legal); end
    total++; if (out_data !== 20'd0) begin bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
    total++; if (change_row !== 1'b0) begin bad++; $display("FAIL reset_crow: got %b want 0", change_row); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit ok;
    int exp_d [4] = '{19, 22, 43, 50};
    bit exp_c [4] = '{0, 1, 0, 1};
    out_ready = 1'b1;
    mv = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(2, 2, 1'b0);
    mv = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(2, 2, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int b = 0; b < 4; b++) begin
      wait_valid(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_timeout[%0d]: got no beat want beat", b); end
      else begin
        if (out_data !== 20'(exp_d[b])) begin
          bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", b, out_data, exp_d[b]);
        end
        total++;
        if (change_row !== exp_c[b]) begin
          bad++; $display("FAIL basic_crow[%0d]: got %b want %b", b, change_row, exp_c[b]);
        end
        total++;
        if (is_legal !== 1'b1) begin bad++; $display("FAIL basic_legal[%0d]: got %b want 1", b, is_legal); end
      end
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_done_busy: got %b want 0", busy); end
  endtask

  // Case 0: 2x3 times 2x2; case 1: ragged A; case 2: A 1x5 exceeds MAX_DIM.
  task automatic test_illegal;
    bit ok;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        mv = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_mat(2, 3, 1'b0);
        mv = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_mat(2, 2, 1'b0);
      end else if (t == 1) begin
        send_elem(8'd1, 1'b0, 1'b0, 1'b0);
        send_elem(8'd2, 1'b1, 1'b0, 1'b0);
        send_elem(8'd3, 1'b1, 1'b1, 1'b0);
        mv = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_mat(2, 1, 1'b0);
      end else begin
        mv = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_mat(1, 5, 1'b0);
        send_mat(5, 1, 1'b0);
      end
      wait_valid(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL illegal_timeout[%0d]: got no beat want beat", t); end
      else begin
        if (is_legal !== 1'b0) begin bad++; $display("FAIL illegal_flag[%0d]: got %b want 0", t, is_legal); end
        total++;
        if (out_data !== 20'd0) begin bad++; $display("FAIL illegal_data[%0d]: got %0d want 0", t, out_data); end
        total++;
        if (change_row !== 1'b0) begin bad++; $display("FAIL illegal_crow[%0d]: got %b want 0", t, change_row); end
      end
      @(posedge clk); #1;
      total++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL illegal_single[%0d]: got valid=%b busy=%b want 0 0", t, valid, busy);
      end
    end
    mv = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(1, 1, 1'b0);
    mv = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(1, 1, 1'b0);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 20'd6 || is_legal !== 1'b1) begin
      bad++; $display("FAIL illegal_next: got ok=%b data=%0d legal=%b want 1 6 1", ok, out_data, is_legal);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed;
    bit ok;
    out_ready = 1'b1;
    mv = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(1, 1, 1'b1);
    mv = '{128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(1, 1, 1'b1);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 20'd128) begin
      bad++; $display("FAIL signed_m1xm128: got ok=%b data=%0d want 1 128", ok, out_data);
    end
    total++;
    if (change_row !== 1'b1) begin bad++; $display("FAIL signed_crow: got %b want 1", change_row); end
    @(posedge clk); #1;
    mv = '{254, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(1, 2, 1'b1);
    mv = '{4, 251, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_mat(2, 1, 1'b1);
    wait_valid(ok);
    total++;
    if (!ok || out_data !== 20'hFFFE9) begin
      bad++; $display("FAIL signed_dot: got ok=%b data=%h want 1 fffe9", ok, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit ok;
    int seen = 0;
    out_ready = 1'b0;
    for (int n = 0; n < 16; n++) mv[n] = 255;
    send_mat(4, 4, 1'b0);
    send_mat(4, 4, 1'b0);
    for (int b = 0; b < 16; b++) begin
      wait_valid(ok);
      if (!ok) break;
      seen++;
      total++;
      if (out_data !== 20'd260100 || change_row !== ((b % 4) == 3)) begin
        bad++; $display("FAIL bp_beat[%0d]: got %0d crow=%b want 260100 crow=%b",
                        b, out_data, change_row, (b % 4) == 3);
      end
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || out_data !== 20'd260100 || change_row !== ((b % 4) == 3)) begin
        bad++; $display("FAIL bp_hold[%0d]: got valid=%b data=%0d want 1 260100", b, valid, out_data);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    total++; if (seen != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_done_busy: got %b want 0", busy); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    for (int t = 0; t < 2; t++) begin
      mv = '{9, 9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      if (t == 0) begin
        out_ready = 1'b1;
        send_mat(2, 2, 1'b0);
        send_elem(8'd7, 1'b0, 1'b0, 1'b0);
      end else begin
        out_ready = 1'b0;
        send_mat(2, 2, 1'b0);
        send_mat(2, 2, 1'b0);
        wait_valid(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_timeout: got no beat want beat"); end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        bad++; $display("FAIL rstmid_state[%0d]: got busy=%b valid=%b want 0 0", t, busy, valid);
      end
      out_ready = 1'b1;
      mv = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      send_mat(1, 1, 1'b0);
      mv = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      send_mat(1, 1, 1'b0);
      wait_valid(ok);
      total++;
      if (!ok || out_data !== 20'd15 || change_row !== 1'b1 || is_legal !== 1'b1) begin
        bad++; $display("FAIL rstmid_after[%0d]: got ok=%b data=%0d crow=%b want 1 15 1",
                        t, ok, out_data, change_row);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; col_end = 1'b0; row_end = 1'b0;
    is_signed = 1'b0; out_ready = 1'b1;
    test_reset;
    test_basic;
    test_illegal;
    test_signed;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
